// File: rtl/if_id_decode_reg.sv
// IF/ID pipeline register with early immediate-select / rd-write / illegal decode.
// Holds on stall, inserts a bubble on flush or invalid fetch, counts bubble cycles.
module if_id_decode_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_pc,
   input  logic [31:0]      if_inst,
   input  logic             stall,
   input  logic             flush,
   output logic             id_valid,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_inst,
   output logic [2:0]       id_sext_op,
   output logic             id_rf_we,
   output logic             id_illegal,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [2:0]  sext_op;
      logic        rf_we;
      logic        illegal;
   } id_state_t;

   localparam logic [2:0] SX_I    = 3'b000;
   localparam logic [2:0] SX_S    = 3'b001;
   localparam logic [2:0] SX_B    = 3'b010;
   localparam logic [2:0] SX_J    = 3'b011;
   localparam logic [2:0] SX_U    = 3'b100;
   localparam logic [2:0] SX_NONE = 3'b111;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   localparam id_state_t BUBBLE = '{valid: 1'b0, pc: RESET_PC, inst: NOP_INST,
                                    sext_op: SX_I, rf_we: 1'b0, illegal: 1'b0};

   id_state_t        state_d, state_q;
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

   logic [2:0] dec_sext_op;
   logic       dec_rf_we;
   logic       dec_illegal;
   logic       rd_nz;

   assign rd_nz = |if_inst[11:7];

   // Decode of the fetched word; only consulted when it is actually loaded.
   always_comb begin
      dec_sext_op = SX_NONE;
      dec_rf_we   = 1'b0;
      dec_illegal = 1'b1;
      if (if_inst[1:0] == 2'b11) begin
         unique case (if_inst[6:2])
            5'b00100, 5'b00000, 5'b11001: begin // op-imm, load, jalr
               dec_sext_op = SX_I;
               dec_rf_we   = rd_nz;
               dec_illegal = 1'b0;
            end
            5'b01000: begin // store
               dec_sext_op = SX_S;
               dec_illegal = 1'b0;
            end
            5'b11000: begin // branch
               dec_sext_op = SX_B;
               dec_illegal = 1'b0;
            end
            5'b11011: begin // jal
               dec_sext_op = SX_J;
               dec_rf_we   = rd_nz;
               dec_illegal = 1'b0;
            end
            5'b01101, 5'b00101: begin // lui, auipc
               dec_sext_op = SX_U;
               dec_rf_we   = rd_nz;
               dec_illegal = 1'b0;
            end
            5'b01100: begin // reg-reg: no immediate, select left at I
               dec_sext_op = SX_I;
               dec_rf_we   = rd_nz;
               dec_illegal = 1'b0;
            end
            5'b00011, 5'b11100: begin // fence, system
               dec_sext_op = SX_I;
               dec_illegal = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Priority flush > stall > load; a flush during a stall drops the held instruction.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = BUBBLE;
      end else if (!stall) begin
         if (if_valid) begin
            state_d.valid   = 1'b1;
            state_d.pc      = if_pc;
            state_d.inst    = if_inst;
            state_d.sext_op = dec_sext_op;
            state_d.rf_we   = dec_rf_we;
            state_d.illegal = dec_illegal;
         end else begin
            state_d = BUBBLE;
         end
      end
   end

   // Counts every edge that leaves ID empty, held bubbles included.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!state_d.valid && bubble_cnt_q != CNT_MAX)
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= BUBBLE;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign id_valid   = state_q.valid;
   assign id_pc      = state_q.pc;
   assign id_inst    = state_q.inst;
   assign id_sext_op = state_q.sext_op;
   assign id_rf_we   = state_q.rf_we;
   assign id_illegal = state_q.illegal;
   assign bubble_cnt = bubble_cnt_q;

endmodule
